// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the RAM access controller and its arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  localparam int unsigned MEM_DEPTH_DEF = 128;
  localparam int unsigned TIMEOUT_DEF   = 15;

endpackage

// File: rtl/mem_req_arbiter.sv
// Fixed-priority 2:1 request selector: data port wins over instruction fetch.
module mem_req_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              enable,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              fetch_gnt,
  output logic              data_gnt,
  output logic              sel_valid,
  output port_t             sel_port,
  output logic              sel_we,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [DATA_W-1:0] sel_wdata
);

  always_comb begin
    data_gnt  = enable & data_req;
    fetch_gnt = enable & fetch_req & ~data_req;
    sel_valid = enable & (data_req | fetch_req);
    if (data_req) begin
      sel_port  = PORT_DATA;
      sel_we    = data_we;
      sel_addr  = data_addr;
      sel_wdata = data_wdata;
    end else begin
      // Fetches are always reads; write data is a don't-care.
      sel_port  = PORT_FETCH;
      sel_we    = 1'b0;
      sel_addr  = fetch_addr;
      sel_wdata = '0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one RAM access at a time for the fetch and load/store ports,
// enforcing the en-low re-arm cycle, address range trap and ready timeout.
module mem_access_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [7:0]      TMO_LAST  = 8'(TIMEOUT - 1);

  state_t            state;
  port_t             cur_port;
  logic              cur_we;
  logic [7:0]        tmo_cnt;

  logic              sel_valid;
  port_t             sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  mem_req_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_arb (
    .enable     (state == ST_IDLE),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .fetch_gnt  (fetch_gnt),
    .data_gnt   (data_gnt),
    .sel_valid  (sel_valid),
    .sel_port   (sel_port),
    .sel_we     (sel_we),
    .sel_addr   (sel_addr),
    .sel_wdata  (sel_wdata)
  );

  assign in_range = {1'b0, sel_addr} < DEPTH_LIM;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_port    <= PORT_FETCH;
      cur_we      <= 1'b0;
      tmo_cnt     <= '0;
      mem_en      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      data_valid  <= 1'b0;
      data_rdata  <= '0;
      err         <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      err         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            cur_port <= sel_port;
            cur_we   <= sel_we;
            if (in_range) begin
              mem_en      <= 1'b1;
              mem_read    <= ~sel_we;
              mem_write   <= sel_we;
              mem_address <= sel_addr;
              mem_wdata   <= sel_wdata;
              tmo_cnt     <= '0;
              state       <= ST_ACCESS;
            end else begin
              // Out-of-range: complete immediately with an error, RAM untouched.
              err <= 1'b1;
              if (sel_port == PORT_DATA) begin
                data_valid <= 1'b1;
                data_rdata <= '0;
              end else begin
                fetch_valid <= 1'b1;
                fetch_data  <= '0;
              end
              state <= ST_RECOVER;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            mem_en    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (cur_port == PORT_DATA) begin
              data_valid <= 1'b1;
              if (!cur_we) data_rdata <= mem_rdata;
            end else begin
              fetch_valid <= 1'b1;
              fetch_data  <= mem_rdata;
            end
            state <= ST_RECOVER;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_en    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err       <= 1'b1;
            if (cur_port == PORT_DATA) begin
              data_valid <= 1'b1;
              data_rdata <= '0;
            end else begin
              fetch_valid <= 1'b1;
              fetch_data  <= '0;
            end
            state <= ST_RECOVER;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_RECOVER: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: behavioural RAM with 3-cycle ready plus a reference memory model.
module tb_mem_access_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_req, data_req, data_we;
  logic [7:0] fetch_addr, data_addr, data_wdata;
  logic       fetch_gnt, fetch_valid, data_gnt, data_valid;
  logic [7:0] fetch_data, data_rdata;
  logic       mem_en, mem_read, mem_write, mem_ready, busy, err;
  logic [7:0] mem_address, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .MEM_DEPTH (128),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_valid  (data_valid),
    .data_rdata  (data_rdata),
    .mem_en      (mem_en),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .err         (err)
  );

  // RAM environment: ready on the third consecutive enabled cycle.
  logic [7:0] ram [128];
  logic       init_we;
  logic [6:0] init_addr;
  logic [7:0] init_data;
  logic [1:0] rdy_cnt;
  logic       ram_stall;

  always @(posedge clk) begin
    if (init_we) ram[init_addr] <= init_data;
    else if (mem_en && mem_ready && mem_write) ram[mem_address[6:0]] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (!mem_en) rdy_cnt <= 2'd0;
    else if (rdy_cnt != 2'd3) rdy_cnt <= rdy_cnt + 2'd1;
  end

  assign mem_ready = mem_en && !ram_stall && (rdy_cnt == 2'd2);
  assign mem_rdata = ram[mem_address[6:0]];

  logic [7:0] ref_mem [128];
  logic [7:0] exp_fd, exp_drd;
  int checks = 0;
  int errors = 0;

  task automatic test_reset();
    checks++;
    if ({fetch_gnt, fetch_valid, data_gnt, data_valid, mem_en, mem_read, mem_write, busy, err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {fetch_gnt, fetch_valid, data_gnt, data_valid, mem_en, mem_read, mem_write, busy, err});
    end
    checks++;
    if ({fetch_data, data_rdata, mem_address, mem_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {fetch_data, data_rdata, mem_address, mem_wdata});
    end
  endtask

  task automatic run_txn(input bit is_data, input bit we, input logic [7:0] addr,
                         input logic [7:0] wd, input bit stall, input string tag);
    bit         oor, exp_err, got_err, other_v, both_v;
    logic [7:0] exp_dat, got_dat;
    int         exp_vcyc, exp_en, vcyc, en_cnt, idle_cyc;
    oor      = (addr >= 8'd128);
    exp_err  = oor || stall;
    exp_vcyc = oor ? 1 : (stall ? TO + 1 : 4);
    exp_en   = oor ? 0 : (stall ? TO : 3);
    if (exp_err) exp_dat = 8'h00;
    else if (we) exp_dat = exp_drd;
    else exp_dat = ref_mem[addr[6:0]];
    vcyc = 0; en_cnt = 0; idle_cyc = 0; got_err = 0; got_dat = 8'hxx;
    other_v = 0; both_v = 0;

    @(negedge clk);
    ram_stall = stall;
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd;
    end else begin
      fetch_req = 1'b1; fetch_addr = addr;
    end
    #1;
    checks++;
    if ({fetch_gnt, data_gnt} !== (is_data ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL %s gnt got %b exp %b", tag, {fetch_gnt, data_gnt}, (is_data ? 2'b01 : 2'b10));
    end

    for (int i = 1; i <= TO + 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        fetch_req = 1'b0; data_req = 1'b0;
        if (exp_en > 0) begin
          checks++;
          if ({mem_address, mem_read, mem_write} !== {addr, ~we, we}) begin
            errors++;
            $display("FAIL %s mem_cmd got %h/%b%b exp %h/%b%b", tag, mem_address, mem_read, mem_write, addr, ~we, we);
          end
          if (we) begin
            checks++;
            if (mem_wdata !== wd) begin
              errors++;
              $display("FAIL %s mem_wdata got %h exp %h", tag, mem_wdata, wd);
            end
          end
        end
      end
      if (mem_en) en_cnt++;
      if (fetch_valid && data_valid) both_v = 1;
      if (is_data ? fetch_valid : data_valid) other_v = 1;
      if ((is_data ? data_valid : fetch_valid) && vcyc == 0) begin
        vcyc    = i;
        got_dat = is_data ? data_rdata : fetch_data;
        got_err = err;
      end
      if (vcyc != 0 && !busy) begin
        idle_cyc = i;
        break;
      end
    end

    checks++;
    if (vcyc != exp_vcyc) begin
      errors++;
      $display("FAIL %s valid_cycle got %0d exp %0d", tag, vcyc, exp_vcyc);
    end
    checks++;
    if (got_dat !== exp_dat || got_err !== exp_err) begin
      errors++;
      $display("FAIL %s result got %h err %b exp %h err %b", tag, got_dat, got_err, exp_dat, exp_err);
    end
    checks++;
    if (en_cnt != exp_en) begin
      errors++;
      $display("FAIL %s mem_en_cycles got %0d exp %0d", tag, en_cnt, exp_en);
    end
    checks++;
    if (idle_cyc != exp_vcyc + 1 || other_v || both_v) begin
      errors++;
      $display("FAIL %s idle_cycle got %0d exp %0d stray_valid %b", tag, idle_cyc, exp_vcyc + 1, other_v | both_v);
    end

    if (!exp_err && we) ref_mem[addr[6:0]] = wd;
    if (is_data) exp_drd = exp_dat;
    else exp_fd = exp_dat;
    ram_stall = 1'b0;
  endtask

  task automatic test_fetch();
    run_txn(1'b0, 1'b0, 8'd12, 8'h00, 1'b0, "fetch12");
  endtask

  task automatic test_store_load();
    run_txn(1'b1, 1'b1, 8'd40, 8'h5C, 1'b0, "store40");
    checks++;
    if (ram[40] !== 8'h5C) begin
      errors++;
      $display("FAIL ram40 got %h exp 5c", ram[40]);
    end
    run_txn(1'b1, 1'b0, 8'd40, 8'h00, 1'b0, "load40");
  endtask

  task automatic test_simultaneous();
    int dv, fv, fg;
    logic [7:0] dd, fd;
    dv = 0; fv = 0; fg = 0; dd = 8'hxx; fd = 8'hxx;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 8'd7;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'd11;
    #1;
    checks++;
    if ({fetch_gnt, data_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL simul_first_gnt got %b exp 01", {fetch_gnt, data_gnt});
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) data_req = 1'b0;
      if (data_valid && dv == 0) begin dv = i; dd = data_rdata; end
      if (fetch_valid && fv == 0) begin fv = i; fd = fetch_data; end
      if (fetch_gnt && fg == 0) fg = i;
      if (fg != 0 && i > fg) fetch_req = 1'b0;
    end
    fetch_req = 1'b0;
    checks++;
    if (dv != 4 || dd !== ref_mem[11]) begin
      errors++;
      $display("FAIL simul_data got cyc %0d val %h exp cyc 4 val %h", dv, dd, ref_mem[11]);
    end
    checks++;
    if (fg != 5) begin
      errors++;
      $display("FAIL simul_fetch_gnt got %0d exp 5", fg);
    end
    checks++;
    if (fv != 9 || fd !== ref_mem[7]) begin
      errors++;
      $display("FAIL simul_fetch got cyc %0d val %h exp cyc 9 val %h", fv, fd, ref_mem[7]);
    end
    exp_drd = ref_mem[11];
    exp_fd  = ref_mem[7];
  endtask

  task automatic test_out_of_range();
    run_txn(1'b1, 1'b0, 8'd200, 8'h00, 1'b0, "oor_load200");
    run_txn(1'b0, 1'b0, 8'd128, 8'h00, 1'b0, "oor_fetch128");
    run_txn(1'b1, 1'b0, 8'd127, 8'h00, 1'b0, "edge_load127");
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 8'd50, 8'h00, 1'b1, "timeout_load");
    run_txn(1'b1, 1'b0, 8'd11, 8'h00, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_mid_access();
    bit stray;
    stray = 0;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 8'd12;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, busy, fetch_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got en/busy/valid %b exp 000", {mem_en, busy, fetch_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fetch_valid || data_valid || busy) stray = 1;
    end
    checks++;
    if (stray || fetch_data !== 8'h00 || data_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_after got stray %b data %h/%h exp 0 00/00", stray, fetch_data, data_rdata);
    end
    exp_fd = 8'h00; exp_drd = 8'h00;
    run_txn(1'b0, 1'b0, 8'd12, 8'h00, 1'b0, "fetch12_after_rst");
  endtask

  task automatic test_random();
    bit         isd, we, st;
    logic [7:0] a, w;
    for (int n = 0; n < 40; n++) begin
      isd = 1'($urandom_range(0, 1));
      we  = isd ? 1'($urandom_range(0, 1)) : 1'b0;
      a   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      w   = 8'($urandom);
      st  = ($urandom_range(0, 9) == 0);
      run_txn(isd, we, a, w, st, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    ram_stall = 1'b0;
    exp_fd = 8'h00; exp_drd = 8'h00;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'($urandom);
    ref_mem[12] = 8'hAB;
    ref_mem[11] = 8'd10;
    ref_mem[7]  = 8'd32;
    init_we = 1'b1;
    for (int i = 0; i < 128; i++) begin
      init_addr = 7'(i);
      init_data = ref_mem[i];
      @(negedge clk);
    end
    init_we = 1'b0;
    test_reset();
    rst_n = 1'b1;
    test_fetch();
    test_store_load();
    test_simultaneous();
    test_out_of_range();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
